rgb_frame_capture: RTL and testbench

RGB_FRAME_CAPTURE -- requirements
Module: rgb_frame_capture

---
 rtl/video_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 20 ++
 rtl/rgb_frame_capture.sv | 131 +++++++++++++
 tb/tb_rgb_frame_capture.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared state encoding and pixel-format helper for the RGB frame capture path.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    // RGB565 -> RGB888 by zero-filling the low bits of each channel (no rounding).
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
        return {pix[15:11], 3'b000, pix[10:5], 2'b00, pix[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Single-register edge detector; FALLING selects which transition produces the pulse.
module sync_edge_det #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_d <= 1'b0;
        else        sig_d <= sig;
    end

    assign pulse = FALLING ? (sig_d & ~sig) : (sig & ~sig_d);

endmodule

// File: rtl/rgb_frame_capture.sv
// Captures one selected RGB565 frame after arm and emits RGB888 writes at pixel*3 byte addresses.
//
//   state         | meaning
//   --------------+---------------------------------------------------------
//   ST_IDLE       | waiting for arm
//   ST_WAIT_FRAME | counting vs edges until frame FRAME_SEL starts
//   ST_CAPTURE    | writing pixels until V_ACTIVE lines or an early vs edge
//   ST_DONE       | one-cycle completion state, done pulses on entry
module rgb_frame_capture #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int RGB_WIDTH  = 16,
    parameter int FRAME_SEL  = 1,
    parameter int ADDR_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  in_vs,
    input  logic                  in_de,
    input  logic [RGB_WIDTH-1:0]  in_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [23:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            frame_cnt
);
    import video_pkg::*;

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [3:0] SEL_CNT   = 4'(FRAME_SEL);
    // Zero or out-of-range selections can never be matched by the 4-bit counter.
    localparam bit         SEL_VALID = (FRAME_SEL >= 1) && (FRAME_SEL <= 15);

    cap_state_t            state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  vs_rise;
    logic                  de_fall;
    logic [3:0]            frame_cnt_nxt;
    logic [ADDR_WIDTH-1:0] pix_addr;

    sync_edge_det #(.FALLING(1'b0)) u_vs_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (in_vs),
        .pulse (vs_rise)
    );

    sync_edge_det #(.FALLING(1'b1)) u_de_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (in_de),
        .pulse (de_fall)
    );

    assign frame_cnt_nxt = frame_cnt + 4'd1;
    assign pix_addr = (ADDR_WIDTH'(y) * ADDR_WIDTH'(H_ACTIVE) + ADDR_WIDTH'(x)) * ADDR_WIDTH'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
            x         <= '0;
            y         <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            // arm wins over a coincident vs edge, so that edge is never counted
            if (arm) begin
                state     <= ST_WAIT_FRAME;
                busy      <= 1'b1;
                err       <= 1'b0;
                frame_cnt <= '0;
                x         <= '0;
                y         <= '0;
            end else begin
                if (busy && vs_rise) frame_cnt <= frame_cnt_nxt;
                case (state)
                    ST_IDLE: ;
                    ST_WAIT_FRAME: begin
                        if (vs_rise && SEL_VALID && (frame_cnt_nxt == SEL_CNT)) begin
                            state <= ST_CAPTURE;
                            x     <= '0;
                            y     <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (vs_rise) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (de_fall) begin
                            x <= '0;
                            y <= y + YW'(1);
                            if (x != XW'(H_ACTIVE)) err <= 1'b1;
                            if (y == YW'(V_ACTIVE - 1)) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (in_de) begin
                            // Overlong lines are flagged but never written past the line end.
                            if (x < XW'(H_ACTIVE)) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_addr;
                                wr_data <= rgb565_to_888(in_data[15:0]);
                                x       <= x + XW'(1);
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_frame_capture.sv
// Scoreboard bench: two captures (FRAME_SEL 1 and 2) share stimulus; a frame-level model predicts outputs.
module tb_rgb_frame_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 21;

    logic clk = 1'b0;
    logic rst_n, arm, in_vs, in_de;
    logic [15:0] in_data;

    logic [1:0]         wr_en_v, busy_v, done_v, err_v;
    logic [1:0][AW-1:0] wr_addr_v;
    logic [1:0][23:0]   wr_data_v;
    logic [1:0][3:0]    fc_v;

    always #5 clk = ~clk;

    rgb_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .RGB_WIDTH(16), .FRAME_SEL(1), .ADDR_WIDTH(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .frame_cnt(fc_v[0])
    );

    rgb_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .RGB_WIDTH(16), .FRAME_SEL(2), .ADDR_WIDTH(AW)) dut2 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .frame_cnt(fc_v[1])
    );

    typedef struct {
        bit is_done;
        int addr;
        int data;
        bit err;
        int fc;
        bit chk_gap;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wr[2];

    bit m_act[2];
    bit m_cap[2];
    bit m_err[2];
    int m_fc[2];
    int m_y[2];

    logic [15:0] pix[0:7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic int exp888(input int p);
        int r, g, b;
        r = (p / 2048) % 32;
        g = (p / 32) % 64;
        b = p % 32;
        return (r * 8) * 65536 + (g * 4) * 256 + (b * 8);
    endfunction

    task automatic push(input int i, input ev_t ev);
        if (i == 0) q0.push_back(ev);
        else        q1.push_back(ev);
    endtask

    task automatic push_wr(input int i, input int y, input int p, input int d);
        ev_t ev;
        ev = '{is_done: 1'b0, addr: (y * H + p) * 3, data: exp888(d), err: 1'b0, fc: 0, chk_gap: 1'b0};
        push(i, ev);
    endtask

    task automatic push_done(input int i, input bit e, input bit g);
        ev_t ev;
        ev = '{is_done: 1'b1, addr: 0, data: 0, err: e, fc: m_fc[i], chk_gap: g};
        push(i, ev);
    endtask

    // Reference model: frames/lines level, frame selection counted from 1 after arm.
    task automatic m_arm();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b1; m_cap[i] = 1'b0; m_err[i] = 1'b0; m_fc[i] = 0; m_y[i] = 0;
        end
    endtask

    task automatic m_vs();
        for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
                m_fc[i] = (m_fc[i] + 1) % 16;
                if (m_cap[i]) begin
                    push_done(i, 1'b1, 1'b0);
                    m_cap[i] = 1'b0;
                    m_act[i] = 1'b0;
                end else if (m_fc[i] == i + 1) begin
                    m_cap[i] = 1'b1;
                    m_y[i] = 0;
                end
            end
        end
    endtask

    task automatic m_line(input int len);
        for (int i = 0; i < 2; i++) begin
            if (m_cap[i]) begin
                for (int p = 0; p < len; p++) begin
                    if (p < H) push_wr(i, m_y[i], p, int'(pix[p]));
                    else       m_err[i] = 1'b1;
                end
                if (len != H) m_err[i] = 1'b1;
                m_y[i]++;
                if (m_y[i] == V) begin
                    push_done(i, m_err[i], len <= H);
                    m_cap[i] = 1'b0;
                    m_act[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pix();
        for (int p = 0; p < 8; p++) pix[p] = 16'($urandom);
    endtask

    task automatic do_arm(input bit with_vs);
        m_arm();
        arm = 1'b1;
        if (with_vs) in_vs = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_busy_after_arm", i), busy_v[i], 1'b1);
            chk($sformatf("d%0d_fc_after_arm", i), fc_v[i], 4'd0);
            chk($sformatf("d%0d_err_after_arm", i), err_v[i], 1'b0);
        end
        in_vs = 1'b0;
        tick();
    endtask

    task automatic send_vs();
        m_vs();
        in_vs = 1'b1;
        tick();
        in_vs = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic send_line(input int len);
        m_line(len);
        for (int p = 0; p < len; p++) begin
            in_de = 1'b1;
            in_data = pix[p];
            tick();
        end
        in_de = 1'b0;
        in_data = 16'h0;
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic send_line_reset(input int rst_at);
        for (int i = 0; i < 2; i++)
            if (m_cap[i])
                for (int p = 0; p < rst_at; p++) push_wr(i, m_y[i], p, int'(pix[p]));
        for (int p = 0; p < rst_at; p++) begin
            in_de = 1'b1;
            in_data = pix[p];
            tick();
        end
        in_data = pix[rst_at];
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_rst_wr_en", i), wr_en_v[i], 1'b0);
            chk($sformatf("d%0d_rst_wr_addr", i), wr_addr_v[i], 0);
            chk($sformatf("d%0d_rst_wr_data", i), wr_data_v[i], 0);
            chk($sformatf("d%0d_rst_busy", i), busy_v[i], 1'b0);
            chk($sformatf("d%0d_rst_err", i), err_v[i], 1'b0);
            chk($sformatf("d%0d_rst_fc", i), fc_v[i], 4'd0);
            m_act[i] = 1'b0;
            m_cap[i] = 1'b0;
        end
        tick();
        tick();
        in_de = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_event(input int i);
        ev_t ev;
        bit have;
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            chk($sformatf("d%0d_unexpected_output", i), {wr_en_v[i], done_v[i]}, 2'b00);
            return;
        end
        if (i == 0) ev = q0.pop_front();
        else        ev = q1.pop_front();
        chk($sformatf("d%0d_done_vs_write", i), done_v[i], ev.is_done);
        if (!ev.is_done) begin
            chk($sformatf("d%0d_wr_addr", i), wr_addr_v[i], ev.addr);
            chk($sformatf("d%0d_wr_data", i), wr_data_v[i], ev.data);
            last_wr[i] = cyc;
        end else begin
            chk($sformatf("d%0d_done_err", i), err_v[i], ev.err);
            chk($sformatf("d%0d_done_frame_cnt", i), fc_v[i], ev.fc);
            chk($sformatf("d%0d_done_busy", i), busy_v[i], 1'b0);
            if (ev.chk_gap) chk($sformatf("d%0d_done_latency", i), cyc - last_wr[i], 1);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++)
                if (wr_en_v[i] || done_v[i]) check_event(i);
        end
    end

    initial begin
        int nfr, nl, len, r;
        rst_n = 1'b0; arm = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_data = 16'h0;
        last_wr[0] = 0; last_wr[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_cap[i] = 1'b0; m_err[i] = 1'b0; m_fc[i] = 0; m_y[i] = 0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_reset_wr_en", i), wr_en_v[i], 1'b0);
            chk($sformatf("d%0d_reset_busy", i), busy_v[i], 1'b0);
            chk($sformatf("d%0d_reset_done", i), done_v[i], 1'b0);
            chk($sformatf("d%0d_reset_err", i), err_v[i], 1'b0);
            chk($sformatf("d%0d_reset_fc", i), fc_v[i], 4'd0);
            chk($sformatf("d%0d_reset_wr_data", i), wr_data_v[i], 0);
        end
        rst_n = 1'b1;
        tick();

        // Full red frame for FRAME_SEL=1, then a second frame only FRAME_SEL=2 takes.
        do_arm(1'b0);
        send_vs();
        for (int p = 0; p < 8; p++) pix[p] = 16'hF800;
        send_line(H);
        send_line(H);
        send_vs();
        fill_pix();
        send_line(H);
        fill_pix();
        send_line(H);

        // Pure green then pure blue pixel expansion.
        do_arm(1'b0);
        send_vs();
        fill_pix();
        pix[0] = 16'h07E0;
        pix[1] = 16'h001F;
        send_line(H);
        fill_pix();
        send_line(H);

        // Short first line: error, but the next line still starts at pixel H.
        do_arm(1'b0);
        send_vs();
        fill_pix();
        send_line(H - 1);
        fill_pix();
        send_line(H);
        send_vs();
        fill_pix();
        send_line(H);
        fill_pix();
        send_line(H);

        // Frame cut short by vs on both captures.
        do_arm(1'b0);
        send_vs();
        fill_pix();
        send_line(H);
        send_vs();
        fill_pix();
        send_line(H);
        send_vs();

        // arm coincident with a vs edge: the edge must not count as frame 1.
        do_arm(1'b1);
        send_vs();
        fill_pix();
        send_line(H);
        fill_pix();
        send_line(H);
        send_vs();
        fill_pix();
        send_line(H);
        fill_pix();
        send_line(H);

        // Re-arm mid-capture restarts cleanly.
        do_arm(1'b0);
        send_vs();
        fill_pix();
        send_line(H);
        do_arm(1'b0);
        send_vs();
        fill_pix();
        send_line(H + 1);
        fill_pix();
        send_line(H);

        // Reset in the middle of line 1; nothing may follow until the next arm.
        do_arm(1'b0);
        send_vs();
        fill_pix();
        send_line(H);
        fill_pix();
        send_line_reset(2);
        send_vs();
        fill_pix();
        send_line(H);
        fill_pix();
        send_line(H);
        send_vs();
        send_line(H);

        for (int it = 0; it < 25; it++) begin
            do_arm(1'b0);
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                send_vs();
                nl = $urandom_range(V - 1, V + 1);
                for (int l = 0; l < nl; l++) begin
                    r = $urandom_range(0, 5);
                    len = (r == 0) ? H - 1 : (r == 1) ? H + 1 : H;
                    fill_pix();
                    send_line(len);
                end
            end
        end

        repeat (5) tick();
        chk("d0_expected_left", q0.size(), 0);
        chk("d1_expected_left", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
